// File: rtl/fpu_issue_pkg.sv
// rtl/fpu_issue_pkg.sv - shared types for the FPU command issue block
package fpu_issue_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int OP_W   = 6;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    // Opcodes are opaque here; their values come from fpu_params.h.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  x1;
        logic [REG_W-1:0]  x2;
        logic [REG_W-1:0]  y;
        logic [DATA_W-1:0] data;
    } fpu_cmd_t;

endpackage

// File: rtl/fpu_issue_if.sv
// rtl/fpu_issue_if.sv - ready/valid command bus between the issuer and fpu
interface fpu_issue_if;
    logic [5:0]  operation;
    logic [4:0]  x1;
    logic [4:0]  x2;
    logic [4:0]  y;
    logic [31:0] in_data;
    logic        ready;
    logic        valid;
    logic [31:0] out_data;
    logic        cond;

    modport master (
        output operation, x1, x2, y, in_data, ready,
        input  valid, out_data, cond
    );

    modport slave (
        input  operation, x1, x2, y, in_data, ready,
        output valid, out_data, cond
    );
endinterface

// File: rtl/fpu_cmd_fifo.sv
// rtl/fpu_cmd_fifo.sv - synchronous command FIFO holding fpu_cmd_t entries
module fpu_cmd_fifo
    import fpu_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push,
    input  fpu_cmd_t push_data,
    input  logic     pop,
    output fpu_cmd_t pop_data,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    fpu_cmd_t       mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    // Extra pointer bit separates the full and empty cases when indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fpu_issue.sv
// rtl/fpu_issue.sv - buffers core FPU commands and issues them one at a time to fpu
module fpu_issue
    import fpu_issue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_op,
    input  logic [4:0]  cmd_x1,
    input  logic [4:0]  cmd_x2,
    input  logic [4:0]  cmd_y,
    input  logic [31:0] cmd_data,
    fpu_issue_if.master fpu,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_cond,
    output logic [5:0]  res_op,
    output logic        res_timeout,
    output logic        busy
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    fpu_cmd_t   push_cmd;
    fpu_cmd_t   head;
    fpu_cmd_t   issue_q;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       cap_valid;
    logic       cap_timeout;
    logic       res_done;
    logic       ready_q;
    logic [7:0] tmo_cnt;

    assign push_cmd  = '{op: cmd_op, x1: cmd_x1, x2: cmd_x2, y: cmd_y, data: cmd_data};
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    fpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Valid from fpu only matters in ISSUE; it has priority over a same-cycle timeout.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        cap_valid   = 1'b0;
        cap_timeout = 1'b0;
        res_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (fpu.valid) begin
                    cap_valid = 1'b1;
                    state_d   = RESP;
                end else if (tmo_cnt == TMO_LAST) begin
                    cap_timeout = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            issue_q     <= '0;
            ready_q     <= 1'b0;
            tmo_cnt     <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_cond    <= 1'b0;
            res_op      <= '0;
            res_timeout <= 1'b0;
        end else begin
            if (pop) begin
                issue_q <= head;
                ready_q <= 1'b1;
                tmo_cnt <= '0;
            end else if (state_q == ISSUE) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end

            if (cap_valid || cap_timeout) begin
                ready_q     <= 1'b0;
                res_valid   <= 1'b1;
                res_op      <= issue_q.op;
                res_timeout <= cap_timeout;
                res_data    <= cap_valid ? fpu.out_data : '0;
                res_cond    <= cap_valid && fpu.cond;
            end

            if (res_done) begin
                res_valid <= 1'b0;
            end
        end
    end

    // Issue fields simply mirror the last popped command, so they hold after ready falls.
    assign fpu.operation = issue_q.op;
    assign fpu.x1        = issue_q.x1;
    assign fpu.x2        = issue_q.x2;
    assign fpu.y         = issue_q.y;
    assign fpu.in_data   = issue_q.data;
    assign fpu.ready     = ready_q;

    assign busy = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_fpu_issue.sv
// tb/tb_fpu_issue.sv - directed bench for fpu_issue with a small fpu model
module tb_fpu_issue;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    localparam logic [5:0] OP_SET  = 6'h01;
    localparam logic [5:0] OP_FCLT = 6'h0a;
    localparam logic [5:0] OP_FCZ  = 6'h0c;
    localparam logic [5:0] OP_SQRT = 6'h14;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_op = '0;
    logic [4:0]  cmd_x1 = '0;
    logic [4:0]  cmd_x2 = '0;
    logic [4:0]  cmd_y = '0;
    logic [31:0] cmd_data = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_cond;
    logic [5:0]  res_op;
    logic        res_timeout;
    logic        busy;

    fpu_issue_if fif ();

    fpu_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_x1      (cmd_x1),
        .cmd_x2      (cmd_x2),
        .cmd_y       (cmd_y),
        .cmd_data    (cmd_data),
        .fpu         (fif),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_cond    (res_cond),
        .res_op      (res_op),
        .res_timeout (res_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // fpu model: valid on the 3rd cycle of ready, results from a tiny register file
    logic [31:0] regs [32] = '{default: '0};
    logic        m_valid = 1'b0;
    logic [31:0] m_out = '0;
    logic        m_cond = 1'b0;
    int          mcnt = 0;
    bit          never_valid = 1'b0;
    bit          kick = 1'b0;

    assign fif.valid    = m_valid;
    assign fif.out_data = m_out;
    assign fif.cond     = m_cond;

    always @(negedge clk) begin
        if (fif.ready) begin
            mcnt++;
            if (!never_valid && mcnt == 3) begin
                m_valid = 1'b1;
                m_out   = '0;
                m_cond  = 1'b0;
                case (fif.operation)
                    OP_SET:  begin m_out = fif.in_data; regs[fif.y] = fif.in_data; end
                    OP_FCLT: m_cond = (regs[fif.x1] < regs[fif.x2]);
                    OP_FCZ:  m_cond = (regs[fif.x1] == 32'h0);
                    OP_SQRT: begin m_out = 32'h5f3759df - (regs[fif.x1] >> 1); regs[fif.y] = m_out; end
                    default: m_out = '0;
                endcase
            end else begin
                m_valid = kick;
            end
        end else begin
            mcnt    = 0;
            m_valid = kick;
            if (kick) begin
                m_out  = 32'hdeadbeef;
                m_cond = 1'b1;
            end
        end
    end

    // Monitor: completed results, low-gap before each ready rise, high-run lengths
    logic [39:0] resq [$];
    int          gaps [$];
    int          his [$];
    int          lo_run = 0;
    int          hi_run = 0;
    int          cr_low_cnt = 0;

    always @(negedge clk) begin
        if (fif.ready) begin
            if (hi_run == 0) gaps.push_back(lo_run);
            hi_run++;
            lo_run = 0;
        end else begin
            if (hi_run != 0) his.push_back(hi_run);
            hi_run = 0;
            lo_run++;
        end
        if (!cmd_ready) cr_low_cnt++;
        if (rstn && res_valid && res_ready) resq.push_back({res_op, res_data, res_cond, res_timeout});
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] op, input logic [4:0] x1, input logic [4:0] x2,
                        input logic [4:0] y, input logic [31:0] d);
        int n;
        cmd_op = op; cmd_x1 = x1; cmd_x2 = x2; cmd_y = y; cmd_data = d;
        cmd_valid = 1'b1;
        for (n = 0; !cmd_ready && n < 200; n++) tick();
        if (n == 200) check("push_stall", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_results(input int target, input int budget);
        int n;
        for (n = 0; resq.size() < target && n < budget; n++) tick();
        check("res_count", resq.size(), target);
    endtask

    task automatic wait_res_valid(input int budget);
        int n;
        for (n = 0; !res_valid && n < budget; n++) tick();
        check("res_valid_wait", res_valid, 1);
    endtask

    function automatic logic [39:0] rexp(input logic [5:0] op, input logic [31:0] d,
                                         input logic c, input logic t);
        return {op, d, c, t};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gbase;
        int crb;
        int min_gap;
        int bad;

        // Reset state
        tick(); tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_ready", fif.ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_timeout", res_timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_issue", {fif.operation, fif.x1, fif.x2, fif.y, fif.in_data}, 53'h0);
        check("rst_res", {res_op, res_data, res_cond}, 39'h0);
        rstn = 1'b1;
        tick();

        // Single OPSET: ready two edges after push, result one edge after valid
        base = resq.size();
        push(OP_SET, 5'd0, 5'd0, 5'd1, 32'h3f800000);
        check("single_ready_n", fif.ready, 0);
        check("single_busy", busy, 1);
        tick();
        check("single_ready_n1", fif.ready, 1);
        check("single_issue", {fif.operation, fif.y, fif.in_data}, {OP_SET, 5'd1, 32'h3f800000});
        tick(); tick();
        check("single_pre_valid", {fif.ready, res_valid}, 2'b10);
        tick();
        check("single_res_valid", {fif.ready, res_valid}, 2'b01);
        check("single_res", {res_op, res_data, res_cond, res_timeout}, rexp(OP_SET, 32'h3f800000, 0, 0));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("single_res_drop", res_valid, 0);
        wait_results(base + 1, 5);

        // Back-to-back with res_ready tied high
        res_ready = 1'b1;
        base  = resq.size();
        gbase = gaps.size();
        crb   = cr_low_cnt;
        push(OP_SET,  5'd0, 5'd0, 5'd2, 32'h40000000);
        push(OP_FCLT, 5'd0, 5'd1, 5'd0, 32'h0);
        push(OP_SQRT, 5'd0, 5'd0, 5'd1, 32'h0);
        push(OP_FCZ,  5'd0, 5'd0, 5'd0, 32'h0);
        wait_results(base + 4, 200);
        check("b2b_0", resq[base + 0], rexp(OP_SET,  32'h40000000, 0, 0));
        check("b2b_1", resq[base + 1], rexp(OP_FCLT, 32'h0,        1, 0));
        check("b2b_2", resq[base + 2], rexp(OP_SQRT, 32'h5f3759df, 0, 0));
        check("b2b_3", resq[base + 3], rexp(OP_FCZ,  32'h0,        1, 0));
        min_gap = 1000;
        for (int i = gbase; i < gaps.size(); i++) if (gaps[i] < min_gap) min_gap = gaps[i];
        check("b2b_gap_ge2", (min_gap >= 2), 1);
        check("b2b_cmd_ready", cr_low_cnt - crb, 0);

        // Full FIFO: DEPTH queued plus one issued before cmd_ready drops
        res_ready = 1'b0;
        base = resq.size();
        push(OP_SET,  5'd0, 5'd0, 5'd3, 32'h11111111);
        push(OP_SET,  5'd0, 5'd0, 5'd4, 32'h22222222);
        push(OP_FCLT, 5'd1, 5'd0, 5'd0, 32'h0);
        push(OP_FCLT, 5'd0, 5'd4, 5'd0, 32'h0);
        push(OP_FCZ,  5'd3, 5'd0, 5'd0, 32'h0);
        check("full_cmd_ready", cmd_ready, 0);
        repeat (3) tick();
        check("full_hold", {cmd_ready, res_valid}, 2'b01);
        res_ready = 1'b1;
        push(OP_SET,  5'd0, 5'd0, 5'd5, 32'h66666666);
        wait_results(base + 6, 300);
        check("full_0", resq[base + 0], rexp(OP_SET,  32'h11111111, 0, 0));
        check("full_1", resq[base + 1], rexp(OP_SET,  32'h22222222, 0, 0));
        check("full_2", resq[base + 2], rexp(OP_FCLT, 32'h0,        0, 0));
        check("full_3", resq[base + 3], rexp(OP_FCLT, 32'h0,        1, 0));
        check("full_4", resq[base + 4], rexp(OP_FCZ,  32'h0,        0, 0));
        check("full_5", resq[base + 5], rexp(OP_SET,  32'h66666666, 0, 0));

        // Result backpressure: held result, no new issue
        res_ready = 1'b0;
        base = resq.size();
        push(OP_SET, 5'd0, 5'd0, 5'd6, 32'ha5a5a5a5);
        wait_res_valid(20);
        push(OP_FCZ, 5'd3, 5'd0, 5'd0, 32'h0);
        bad = 0;
        repeat (10) begin
            tick();
            if (!res_valid || res_data != 32'ha5a5a5a5 || fif.ready || fif.operation != OP_SET) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_busy", busy, 1);
        res_ready = 1'b1;
        wait_results(base + 2, 50);
        check("bp_0", resq[base + 0], rexp(OP_SET, 32'ha5a5a5a5, 0, 0));
        check("bp_1", resq[base + 1], rexp(OP_FCZ, 32'h0,        0, 0));

        // Timeout: fpu never answers
        res_ready   = 1'b0;
        never_valid = 1'b1;
        base = resq.size();
        push(OP_SET, 5'd0, 5'd0, 5'd7, 32'h12345678);
        wait_res_valid(400);
        check("tmo_res", {res_op, res_data, res_cond, res_timeout}, rexp(OP_SET, 32'h0, 0, 1));
        check("tmo_ready_low", fif.ready, 0);
        tick();
        check("tmo_ready_len", his[his.size() - 1], TIMEOUT);
        never_valid = 1'b0;
        res_ready   = 1'b1;
        push(OP_FCZ, 5'd0, 5'd0, 5'd0, 32'h0);
        wait_results(base + 2, 50);
        check("tmo_next", resq[base + 1], rexp(OP_FCZ, 32'h0, 1, 0));

        // Reset mid-ISSUE with two commands queued
        never_valid = 1'b1;
        base = resq.size();
        push(OP_SET, 5'd0, 5'd0, 5'd8, 32'h01020304);
        push(OP_SET, 5'd0, 5'd0, 5'd9, 32'h05060708);
        push(OP_SET, 5'd0, 5'd0, 5'd10, 32'h090a0b0c);
        check("rmid_ready", fif.ready, 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("rmid_flags", {cmd_ready, fif.ready, res_valid, res_timeout, busy}, 5'b10000);
        check("rmid_issue", {fif.operation, fif.x1, fif.x2, fif.y, fif.in_data}, 53'h0);
        check("rmid_res", {res_op, res_data, res_cond}, 39'h0);
        never_valid = 1'b0;
        kick = 1'b1;
        tick(); tick();
        kick = 1'b0;
        bad = 0;
        repeat (10) begin
            tick();
            if (res_valid || fif.ready || busy) bad++;
        end
        check("rmid_ignore_valid", bad, 0);
        check("rmid_no_result", resq.size(), base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_issue.md
# fpu_issue

Synthesizable initiator for the FPU ready/valid command interface. It buffers register-level FPU commands from the core in a small FIFO, issues them one at a time to `fpu`, and returns each command's `out_data`/`cond` on a result handshake. It sits between the core's floating-point dispatch stage and `fpu`. It replaces the hand-driven stimulus pattern with a timeout-protected FSM.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- TIMEOUT, 255: maximum cycles `ready` stays high without `valid`; 8-bit counter.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered by the core.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_op  in  6  FPU opcode (`FPU_OP*` from fpu_params.h).
- cmd_x1, cmd_x2, cmd_y  in  5 each  source and destination FPU register indices.
- cmd_data  in  32  immediate for `FPU_OPSET`.
- operation  out  6  to fpu.
- x1, x2, y  out  5 each  to fpu.
- in_data  out  32  to fpu.
- ready  out  1  request to fpu; high while a command is outstanding.
- valid  in  1  fpu completion.
- out_data  in  32  fpu result.
- cond  in  1  fpu compare result (FCLT, FCZ).
- res_valid  out  1  result available.
- res_ready  in  1  core accepts result.
- res_data  out  32  captured out_data.
- res_cond  out  1  captured cond.
- res_op  out  6  opcode of the completed command.
- res_timeout  out  1  result produced by timeout, not by valid.
- busy  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- FSM states are IDLE, ISSUE and RESP.
- IDLE:
  - If the FIFO is non-empty, pop the head into the issue registers (operation, x1, x2, y, in_data).
  - Set ready<=1, clear the timeout counter, go to ISSUE.
- ISSUE:
  - ready stays high; all issue fields are held constant.
  - On valid=1: capture out_data, cond and operation into res_*; set res_timeout<=0, ready<=0, res_valid<=1; go to RESP.
  - Otherwise increment the counter. When counter==TIMEOUT-1: ready<=0, res_data<=0, res_cond<=0, res_timeout<=1, res_valid<=1; go to RESP.
- RESP:
  - res_valid is held until res_ready=1.
  - On handshake: res_valid<=0, go to IDLE.
- valid is ignored outside ISSUE.
- Issue fields hold their last values after ready falls. They are never driven to X.
- FIFO behaviour:
  - Push on cmd_valid&&cmd_ready.
  - Push and pop in the same cycle are both performed.
  - A push while full is impossible because cmd_ready=0.
  - There is no pass-through: a push is visible to IDLE one cycle later.
- Commands complete strictly in order. Exactly one command is outstanding at a time.

## Timing
- Reset values: cmd_ready=1, ready=0, res_valid=0, res_timeout=0, busy=0. operation, x1, x2, y, in_data, res_data, res_cond and res_op are all 0. FIFO is empty, FSM is in IDLE.
- Command pushed at edge N into an empty FIFO with the FSM in IDLE:
  - Pop happens at N+1; ready is high from N+1.
  - This gives 2 edges from acceptance to ready.
- valid sampled at edge M: ready is low and res_valid is high after M.
- res_ready high at edge M+1 (minimum): the next ready rises at M+2 at the earliest.
  - ready is therefore low for at least two cycles between commands. fpu relies on this gap.
- Timeout: ready falls after exactly TIMEOUT cycles high.
- rstn=0 in any state, including ISSUE mid-command: at the next edge all reset values apply and the FIFO is flushed. An fpu valid arriving later is ignored.

## Structure
- fpu_issue_pkg holds:
  - state_t enum {IDLE, ISSUE, RESP};
  - the packed struct fpu_cmd_t {op, x1, x2, y, data}, 53 bits.
- Opcodes are taken from fpu_params.h and are not redefined.
- Sub-module fpu_cmd_fifo is parameterized by DEPTH and holds fpu_cmd_t entries. It has push/pop/full/empty ports and synchronous active-low reset.
- The FSM, timeout counter and result registers live in fpu_issue.

## Test plan
- Single OPSET: push {op=`FPU_OPSET`, y=1, data=0x3f800000}. The fpu model asserts valid 3 cycles after ready. Expect:
  - ready high 2 edges after push with in_data=0x3f800000, y=1;
  - res_valid one edge after valid with res_op=`FPU_OPSET`, res_timeout=0.
- Back-to-back: push 4 commands consecutively (OPSET 0x40000000, FCLT x1=0 x2=1, SQRT_INV_INIT x1=0 y=1, FCZ x1=0) with res_ready tied high. Expect:
  - in-order results;
  - res_cond matches the model for FCLT and FCZ;
  - ready low at least 2 cycles between commands;
  - cmd_ready=1 throughout.
- Full FIFO: hold res_ready=0 and push DEPTH+2 commands. Expect cmd_ready=0 after DEPTH+1 accepts (DEPTH in the FIFO plus 1 issued); no command is lost. Releasing res_ready drains all of them.
- Result backpressure: res_ready=0 for 10 cycles after valid. Expect res_valid and res_data stable, ready low, and no new issue until the handshake.
- Timeout: the model never asserts valid. Expect ready to fall after 255 cycles, then res_valid=1, res_timeout=1, res_data=0. The next command issues normally.
- Reset mid-ISSUE: assert rstn=0 for 1 cycle while ready=1 with 2 commands queued. Expect all reset values and busy=0. A later model valid produces no res_valid.
